// File: rtl/regfile_operand_sequencer.sv
// Operand sequencer for the 8x16 LC-3 register file: decode, RAW-interlocked operand fetch, writeback pass-through.
// Optional macro WB_BYPASS_EN forwards a same-cycle writeback value into a stalled operand capture.
module regfile_operand_sequencer #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int SEL_W  = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ir_valid,
    output logic              ir_ready,
    input  logic [15:0]       ir,
    output logic [SEL_W-1:0]  rd_sel_1,
    output logic [SEL_W-1:0]  rd_sel_2,
    input  logic [DATA_W-1:0] rd_data_1,
    input  logic [DATA_W-1:0] rd_data_2,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [SEL_W-1:0]  op_dr,
    output logic              op_wb,
    input  logic              wb_valid,
    input  logic [SEL_W-1:0]  wb_dr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [SEL_W-1:0]  rf_write_sel,
    output logic              rf_load,
    output logic [DATA_W-1:0] rf_data_in,
    output logic [NREG-1:0]   busy,
    output logic              wb_err
);

    typedef enum logic [1:0] {IDLE, HOLD, OUT} state_t;

    state_t      state;
    logic [15:0] ir_p0;

    function automatic logic signed [DATA_W-1:0] sext5(input logic [4:0] v);
        return {{(DATA_W-5){v[4]}}, v};
    endfunction

    logic [3:0]        opc;
    logic              is_alu, is_imm, is_store, uses_src2, dec_wb;
    logic [SEL_W-1:0]  src1, src2, dr;
    logic              haz1, haz2, hazard;
    logic [DATA_W-1:0] opnd_a, opnd_b_reg, opnd_b;
    logic [NREG-1:0]   busy_nxt;

    assign opc       = ir_p0[15:12];
    assign is_alu    = (opc == 4'b0001) || (opc == 4'b0101);
    assign is_imm    = is_alu && ir_p0[5];
    assign is_store  = (opc == 4'b0011) || (opc == 4'b0111) || (opc == 4'b1011);
    assign uses_src2 = (is_alu && !ir_p0[5]) || is_store;
    assign dec_wb    = is_alu || (opc == 4'b1001) || (opc == 4'b0010) || (opc == 4'b0110) ||
                       (opc == 4'b1010) || (opc == 4'b1110);
    assign src1      = ir_p0[8:6];
    assign src2      = is_store ? ir_p0[11:9] : ir_p0[2:0];
    assign dr        = ir_p0[11:9];

    assign rd_sel_1  = src1;
    assign rd_sel_2  = src2;

`ifdef WB_BYPASS_EN
    logic fwd1, fwd2;
    assign fwd1       = wb_valid && (wb_dr == src1);
    assign fwd2       = wb_valid && (wb_dr == src2) && uses_src2;
    assign haz1       = busy[src1] && !fwd1;
    assign haz2       = uses_src2 && busy[src2] && !fwd2;
    assign opnd_a     = fwd1 ? wb_data : rd_data_1;
    assign opnd_b_reg = fwd2 ? wb_data : rd_data_2;
`else
    // A source being written this cycle still reads the old file value, so wait one more cycle.
    assign haz1       = busy[src1] || (wb_valid && (wb_dr == src1));
    assign haz2       = uses_src2 && (busy[src2] || (wb_valid && (wb_dr == src2)));
    assign opnd_a     = rd_data_1;
    assign opnd_b_reg = rd_data_2;
`endif

    assign hazard = haz1 || haz2 || (dec_wb && busy[dr]);
    assign opnd_b = is_imm ? sext5(ir_p0[4:0]) : opnd_b_reg;

    // Issue sets after writeback clears, so a same-register collision leaves the bit set.
    always_comb begin
        busy_nxt = busy;
        if (wb_valid)
            busy_nxt[wb_dr] = 1'b0;
        if (state == OUT && op_ready && op_wb)
            busy_nxt[op_dr] = 1'b1;
    end

    assign ir_ready     = (state == IDLE) && !Reset;
    assign rf_write_sel = wb_dr;
    assign rf_data_in   = wb_data;
    assign rf_load      = wb_valid && !Reset;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            ir_p0    <= '0;
            busy     <= '0;
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_dr    <= '0;
            op_wb    <= 1'b0;
            wb_err   <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (wb_valid && !busy[wb_dr])
                wb_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (ir_valid) begin
                        ir_p0 <= ir;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!hazard) begin
                        op_a     <= opnd_a;
                        op_b     <= opnd_b;
                        op_dr    <= dr;
                        op_wb    <= dec_wb;
                        op_valid <= 1'b1;
                        state    <= OUT;
                    end
                end
                OUT: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_operand_sequencer.sv
// Bench for regfile_operand_sequencer: table of single-instruction vectors plus hazard/writeback/reset sequences.
module tb_regfile_operand_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] ir;
    logic [2:0]  rd_sel_1, rd_sel_2;
    logic [15:0] rd_data_1, rd_data_2;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a, op_b;
    logic [2:0]  op_dr;
    logic        op_wb;
    logic        wb_valid;
    logic [2:0]  wb_dr;
    logic [15:0] wb_data;
    logic [2:0]  rf_write_sel;
    logic        rf_load;
    logic [15:0] rf_data_in;
    logic [7:0]  busy;
    logic        wb_err;

    int checks = 0;
    int failures = 0;

    logic [15:0] rf [8];
    logic        init_rf;

    regfile_operand_sequencer dut (
        .Clk(Clk), .Reset(Reset),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir),
        .rd_sel_1(rd_sel_1), .rd_sel_2(rd_sel_2),
        .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_dr(op_dr), .op_wb(op_wb),
        .wb_valid(wb_valid), .wb_dr(wb_dr), .wb_data(wb_data),
        .rf_write_sel(rf_write_sel), .rf_load(rf_load), .rf_data_in(rf_data_in),
        .busy(busy), .wb_err(wb_err)
    );

    always #5 Clk = ~Clk;

    // Register file model: combinational read, write on rf_load.
    assign rd_data_1 = rf[rd_sel_1];
    assign rd_data_2 = rf[rd_sel_2];
    always @(posedge Clk) begin
        if (init_rf) begin
            rf[0] <= 16'h0F0F; rf[1] <= 16'h00F0; rf[2] <= 16'h0005; rf[3] <= 16'h0007;
            rf[4] <= 16'h0010; rf[5] <= 16'h5555; rf[6] <= 16'h1234; rf[7] <= 16'hBEEF;
        end else if (rf_load) begin
            rf[rf_write_sel] <= rf_data_in;
        end
    end

    typedef struct {
        logic [15:0] instr;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  dr;
        logic        wb;
        logic [7:0]  busy_after;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; ir_valid = 1'b0; op_ready = 1'b0; wb_valid = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        #1;
    endtask

    task automatic issue(input logic [15:0] instr);
        ir = instr;
        ir_valid = 1'b1;
        #1;
        chk("ir_ready_idle", ir_ready, 1'b1);
        tick();
        ir_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{16'h1283, 16'h0005, 16'h0007, 3'd1, 1'b1, 8'h02};
        vecs[1] = '{16'h193F, 16'h0010, 16'hFFFF, 3'd4, 1'b1, 8'h10};
        vecs[2] = '{16'h5A40, 16'h00F0, 16'h0F0F, 3'd5, 1'b1, 8'h20};
        vecs[3] = '{16'h97BF, 16'h1234, 16'hBEEF, 3'd3, 1'b1, 8'h08};
        vecs[4] = '{16'h75C1, 16'hBEEF, 16'h0005, 3'd2, 1'b0, 8'h00};
        vecs[5] = '{16'h11EF, 16'hBEEF, 16'h000F, 3'd0, 1'b1, 8'h01};
        vecs[6] = '{16'h0E05, 16'h0F0F, 16'h5555, 3'd7, 1'b0, 8'h00};

        Reset = 1'b1; ir_valid = 1'b0; ir = 16'h0; op_ready = 1'b0;
        wb_valid = 1'b0; wb_dr = 3'd0; wb_data = 16'h0; init_rf = 1'b1;
        tick();
        init_rf = 1'b0;
        wb_valid = 1'b1; wb_dr = 3'd5; wb_data = 16'hDEAD;
        #1;
        chk("rst_rf_load", rf_load, 1'b0);
        chk("rst_ir_ready", ir_ready, 1'b0);
        tick();
        wb_valid = 1'b0;
        chk("rst_op_valid", op_valid, 1'b0);
        chk("rst_busy", busy, 8'h00);
        chk("rst_wb_err", wb_err, 1'b0);
        chk("rst_op_a", op_a, 16'h0);
        chk("rst_op_b", op_b, 16'h0);
        chk("rst_op_dr", op_dr, 3'd0);
        chk("rst_op_wb", op_wb, 1'b0);
        Reset = 1'b0;
        #1;
        chk("rst_release_ir_ready", ir_ready, 1'b1);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            issue(vecs[i].instr);
            chk("lat_not_yet", op_valid, 1'b0);
            tick();
            chk("lat_valid", op_valid, 1'b1);
            chk("vec_op_a", op_a, vecs[i].a);
            chk("vec_op_b", op_b, vecs[i].b);
            chk("vec_op_dr", op_dr, vecs[i].dr);
            chk("vec_op_wb", op_wb, vecs[i].wb);
            op_ready = 1'b1;
            tick();
            op_ready = 1'b0;
            chk("vec_busy", busy, vecs[i].busy_after);
            chk("vec_done", op_valid, 1'b0);
        end

        // RAW interlock on R1 released by writeback
        do_reset();
        issue(16'h1283);
        tick();
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        chk("raw_busy_set", busy, 8'h02);
        issue(16'h5A40);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("raw_stall", op_valid, 1'b0);
        end
        chk("raw_busy_hold", busy, 8'h02);
        wb_valid = 1'b1; wb_dr = 3'd1; wb_data = 16'h00AA;
        tick();
        wb_valid = 1'b0;
        chk("raw_busy_clr", busy, 8'h00);
`ifdef WB_BYPASS_EN
        chk("raw_bypass_valid", op_valid, 1'b1);
`else
        chk("raw_extra_stall", op_valid, 1'b0);
        tick();
        chk("raw_valid", op_valid, 1'b1);
`endif
        chk("raw_op_a", op_a, 16'h00AA);
        chk("raw_op_b", op_b, 16'h0F0F);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        chk("raw_busy_r5", busy, 8'h20);
        chk("raw_no_err", wb_err, 1'b0);

        // Writeback to a non-busy register
        wb_valid = 1'b1; wb_dr = 3'd6; wb_data = 16'h7777;
        #1;
        chk("err_rf_load", rf_load, 1'b1);
        chk("err_rf_sel", rf_write_sel, 3'd6);
        chk("err_rf_data", rf_data_in, 16'h7777);
        tick();
        wb_valid = 1'b0;
        chk("err_set", wb_err, 1'b1);
        chk("err_busy", busy, 8'h20);
        repeat (3) tick();
        chk("err_sticky", wb_err, 1'b1);

        // Output held under back-pressure
        issue(16'h97BF);
        tick();
        ir = 16'h1283; ir_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", op_valid, 1'b1);
            chk("bp_op_a", op_a, 16'h7777);
            chk("bp_op_b", op_b, 16'hBEEF);
            chk("bp_op_dr", op_dr, 3'd3);
            chk("bp_ir_ready", ir_ready, 1'b0);
            chk("bp_busy", busy, 8'h20);
        end
        ir_valid = 1'b0;
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        chk("bp_busy_after", busy, 8'h28);
        chk("bp_done", op_valid, 1'b0);

        // Same-edge set and clear of R0
        issue(16'h11EF);
        tick();
        chk("sc_valid", op_valid, 1'b1);
        chk("sc_op_a", op_a, 16'hBEEF);
        chk("sc_op_b", op_b, 16'h000F);
        op_ready = 1'b1; wb_valid = 1'b1; wb_dr = 3'd0; wb_data = 16'h1111;
        tick();
        op_ready = 1'b0; wb_valid = 1'b0;
        chk("sc_set_wins", busy, 8'h29);

        // Reset while stalled in HOLD
        issue(16'h14E0);
        tick(); tick();
        chk("mr_stalled", op_valid, 1'b0);
        Reset = 1'b1; wb_valid = 1'b1; wb_dr = 3'd5; wb_data = 16'hDEAD;
        #1;
        chk("mr_rf_load", rf_load, 1'b0);
        chk("mr_ir_ready", ir_ready, 1'b0);
        tick();
        chk("mr_busy", busy, 8'h00);
        chk("mr_op_valid", op_valid, 1'b0);
        Reset = 1'b0; wb_valid = 1'b0;
        #1;
        chk("mr_idle", ir_ready, 1'b1);
        chk("mr_wb_err", wb_err, 1'b0);
        chk("mr_no_write", rf[5], 16'h5555);
        issue(16'h1283);
        tick();
        chk("mr_reissue_valid", op_valid, 1'b1);
        chk("mr_reissue_a", op_a, 16'h0005);
        chk("mr_reissue_b", op_b, 16'h0007);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
